// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared digit codes and segment patterns for the clock display
package clk_pkg;

  typedef logic [6:0] seg_t;

  localparam int          NUM_DIGITS = 8;
  localparam logic [10:0] DIG_DASH   = 11'd11;
  localparam logic [10:0] DIG_BLANK  = 11'd12;

  // Active-low patterns, bit 6 = g down to bit 0 = a
  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

  localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 11-bit digit code to active-low seven-segment pattern
module seg7_decode
  import clk_pkg::*;
(
  input  logic [10:0] num,
  output logic [6:0]  seg
);

  // Full-width compare so out-of-range codes can never alias onto a digit
  always_comb begin
    seg = SEG_OFF;
    case (num)
      11'd0:     seg = SEG_0;
      11'd1:     seg = SEG_1;
      11'd2:     seg = SEG_2;
      11'd3:     seg = SEG_3;
      11'd4:     seg = SEG_4;
      11'd5:     seg = SEG_5;
      11'd6:     seg = SEG_6;
      11'd7:     seg = SEG_7;
      11'd8:     seg = SEG_8;
      11'd9:     seg = SEG_9;
      DIG_DASH:  seg = SEG_DASH;
      DIG_BLANK: seg = SEG_OFF;
      default:   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit multiplexed display scan with blanking and blink
module seg7_scan_driver
  import clk_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_HZ     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] num,
  input  logic [7:0]  blink_mask,
  output logic [2:0]  light,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int BHP  = CLK_HZ / (2 * BLINK_HZ);
  localparam int SC_W = $clog2(DIV + 1);
  localparam int BC_W = $clog2(BHP + 1);

  localparam logic [SC_W-1:0] SC_LAST    = SC_W'(DIV - 1);
  localparam logic [SC_W-1:0] BLANK_LAST = SC_W'(BLANK_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST    = BC_W'(BHP - 1);
  localparam logic [2:0]      LIGHT_LAST = 3'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]      state;
  logic [SC_W-1:0] sc;
  logic [BC_W-1:0] blink_cnt;
  logic            blink_on;
  logic [6:0]      dec_seg;
  logic [7:0]      an_lit;

  seg7_decode u_decode (
    .num (num),
    .seg (dec_seg)
  );

  // Anode pattern for the current digit, re-evaluated every lit cycle so blink edges land promptly
  always_comb begin
    an_lit = ~(8'h01 << light);
    if (blink_mask[light] && !blink_on) an_lit = AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      sc         <= '0;
      light      <= 3'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (blink_cnt == BC_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      frame_tick <= 1'b0;
      if (!enable) begin
        state <= ST_BLANK;
        sc    <= '0;
        light <= 3'd0;
        an    <= AN_OFF;
        seg   <= SEG_OFF;
      end else if (state == ST_BLANK) begin
        sc <= sc + 1'b1;
        // light has been stable through the dead time, so num has settled by now
        if (sc == BLANK_LAST) begin
          state <= ST_SHOW;
          seg   <= dec_seg;
          an    <= an_lit;
        end
      end else begin
        if (sc == SC_LAST) begin
          state      <= ST_BLANK;
          sc         <= '0;
          light      <= light + 3'd1;
          an         <= AN_OFF;
          seg        <= SEG_OFF;
          frame_tick <= (light == LIGHT_LAST);
        end else begin
          sc <= sc + 1'b1;
          an <= an_lit;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int BHP   = 20;

  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [10:0] num;
  logic [7:0]  blink_mask = 8'h00;
  logic [2:0]  light;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  logic        num_mode = 1'b0;
  logic [10:0] num_fix  = 11'd0;

  int vectors = 0;
  int miscompares = 0;

  assign num = num_mode ? num_fix : 11'({8'b0, light} + 11'd1);

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (BLANK),
    .BLINK_HZ     (25)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .num        (num),
    .blink_mask (blink_mask),
    .light      (light),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_dec(input logic [10:0] c);
    if (c < 11'd10) return SEG_TBL[c[3:0]];
    if (c == 11'd11) return 7'h3F;
    return 7'h7F;
  endfunction

  function automatic logic ref_blink_on(input int k);
    return ((k / BHP) % 2) == 0;
  endfunction

  // Scoreboard: t = cycles since the last reset/disable, k = cycles since the last reset
  initial begin
    logic        s_rst, s_en;
    logic [10:0] s_num, lat;
    logic [7:0]  s_mask, e_an;
    logic [6:0]  e_seg;
    logic [2:0]  e_light;
    logic        e_ft;
    int          t, k, k_old, lt;
    bit          valid;
    valid = 0; t = 0; k = 0; lat = '0;
    forever begin
      @(negedge clk); #2;
      s_rst = rst; s_en = enable; s_num = num; s_mask = blink_mask;
      @(posedge clk); #1;
      e_an = 8'hFF; e_seg = 7'h7F; e_light = 3'd0; e_ft = 1'b0;
      if (s_rst) begin
        t = 0; k = 0; valid = 1;
      end else begin
        k_old = k; k = k + 1;
        if (!s_en) begin
          t = 0;
        end else begin
          if (t % DIV == BLANK - 1) lat = s_num;
          t = t + 1;
          lt = (t / DIV) % 8;
          e_light = 3'(lt);
          e_ft = (t % (8 * DIV)) == 0;
          if (t % DIV >= BLANK) begin
            e_seg = ref_dec(lat);
            e_an = (s_mask[lt] && !ref_blink_on(k_old)) ? 8'hFF : ~(8'h01 << lt);
          end
        end
      end
      if (valid) begin
        chk($sformatf("model light t=%0d", t), 32'(light), 32'(e_light));
        chk($sformatf("model an t=%0d", t), 32'(an), 32'(e_an));
        chk($sformatf("model seg t=%0d", t), 32'(seg), 32'(e_seg));
        chk($sformatf("model dp t=%0d", t), 32'(dp), 32'd1);
        chk($sformatf("model frame_tick t=%0d", t), 32'(frame_tick), 32'(e_ft));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int en_hold;
    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    chk("reset light", 32'(light), 32'd0);
    chk("reset an", 32'(an), 32'hFF);
    chk("reset seg", 32'(seg), 32'h7F);
    chk("reset dp", 32'(dp), 32'd1);
    chk("reset frame_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1 still blank", 32'(an), 32'hFF);
    @(negedge clk);
    chk("t2 an", 32'(an), 32'hFE);
    chk("t2 seg", 32'(seg), 32'h79);
    repeat (70) @(negedge clk);
    chk("slot7 an", 32'(an), 32'h7F);
    chk("slot7 seg", 32'(seg), 32'h00);
    repeat (8) @(negedge clk);
    chk("frame wrap tick", 32'(frame_tick), 32'd1);
    chk("frame wrap light", 32'(light), 32'd0);

    // Special codes and once-per-slot sampling
    num_mode = 1'b1; num_fix = 11'd11;
    repeat (2) @(negedge clk);
    chk("dash seg", 32'(seg), 32'h3F);
    num_fix = 11'd12;
    repeat (10) @(negedge clk);
    chk("blank code seg", 32'(seg), 32'h7F);
    chk("blank code an", 32'(an), 32'hFD);
    num_fix = 11'd1023;
    repeat (10) @(negedge clk);
    chk("1023 seg", 32'(seg), 32'h7F);
    num_fix = 11'd5;
    repeat (3) @(negedge clk);
    chk("mid-show num ignored", 32'(seg), 32'h7F);
    repeat (7) @(negedge clk);
    chk("next slot picks up 5", 32'(seg), 32'h12);

    // Blink on digit 2 from a known blink phase
    num_mode = 1'b0; blink_mask = 8'h04;
    do_reset();
    repeat (15) @(negedge clk);
    chk("blink other digit", 32'(an), 32'hFD);
    repeat (10) @(negedge clk);
    chk("blink digit2 off phase", 32'(an), 32'hFF);
    repeat (175) @(negedge clk);

    // Randomized traffic
    en_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 7) == 0)
        num_fix = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) num_mode = ~num_mode;
      if ($urandom_range(0, 63) == 0) blink_mask = 8'($urandom);
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
        en_hold = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; num_mode = 1'b0; blink_mask = 8'h00;

    // Mid-operation reset at digit 5, sc 5, then a 7-cycle enable drop
    do_reset();
    repeat (55) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset light", 32'(light), 32'd0);
    chk("mid reset an", 32'(an), 32'hFF);
    rst = 1'b0;
    repeat (23) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("disabled an %0d", i), 32'(an), 32'hFF);
      chk($sformatf("disabled seg %0d", i), 32'(seg), 32'h7F);
    end
    enable = 1'b1;
    chk("restart light", 32'(light), 32'd0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
